// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port-b arbiter and its response tag pipeline.
package mem_arb_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic vld;
    logic id;
    logic rd;
  } rsp_tag_t;

endpackage

// File: rtl/mem_rsp_tag_pipe.sv
// Two-stage tag shift register matching the memory's 2-cycle read latency;
// steers each response's valid to the requester that issued the read.
module mem_rsp_tag_pipe
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t tag_i,
  output logic     rvalid0_o,
  output logic     rvalid1_o,
  output logic     busy_o
);

  rsp_tag_t s1_q, s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= tag_i;
      s2_q <= s1_q;
    end
  end

  assign rvalid0_o = s2_q.vld && s2_q.rd && (s2_q.id == REQ_CPU);
  assign rvalid1_o = s2_q.vld && s2_q.rd && (s2_q.id == REQ_LDR);
  assign busy_o    = (s1_q.vld && s1_q.rd) || (s2_q.vld && s2_q.rd);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory port b between the CPU (m0) and the
// loader (m1), with a bounded m1 burst lock and read response steering.
module mem_port_arbiter
  import mem_arb_pkg::rsp_tag_t;
  import mem_arb_pkg::REQ_CPU;
  import mem_arb_pkg::REQ_LDR;
#(
  parameter int ADDR_W   = mem_arb_pkg::ADDR_W,
  parameter int DATA_W   = mem_arb_pkg::DATA_W,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  logic             last_q, last_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_full, lock_hold;
  logic             gnt0, gnt1;
  rsp_tag_t         tag_d;

  always_comb begin
    lock_full = (lock_cnt_q == CNT_W'(LOCK_MAX));
    // The lock only holds m1 once a contended burst is under way, so the
    // post-reset last=1 still hands the first contention to m0.
    lock_hold = m1_lock && (last_q == REQ_LDR) && (lock_cnt_q != '0) && !lock_full;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_valid && m1_valid) begin
        if (lock_full)                          gnt0 = 1'b1;
        else if (lock_hold || last_q == REQ_CPU) gnt1 = 1'b1;
        else                                    gnt0 = 1'b1;
      end else begin
        gnt0 = m0_valid;
        gnt1 = m1_valid;
      end
    end
  end

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_we ? '1 : '0;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we ? '1 : '0;
    end
  end

  always_comb begin
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt0)      last_d = REQ_CPU;
    else if (gnt1) last_d = REQ_LDR;
    if (!m1_lock || gnt0)
      lock_cnt_d = '0;
    else if (gnt1 && m0_valid && !lock_full)
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= REQ_LDR;
      lock_cnt_q <= '0;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    tag_d.vld = gnt0 || gnt1;
    tag_d.id  = gnt1;
    tag_d.rd  = (gnt0 && !m0_we) || (gnt1 && !m1_we);
  end

  mem_rsp_tag_pipe u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_i     (tag_d),
    .rvalid0_o (m0_rvalid),
    .rvalid1_o (m1_rvalid),
    .busy_o    (busy)
  );

  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 2-cycle-latency memory, a per-cycle reference
// model of the arbitration/response rules, and directed literal checks.
module tb_mem_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int LM = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_valid, m0_ready, m0_we, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic m1_valid, m1_ready, m1_we, m1_rvalid, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_we, mem_rdata;
  logic busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory instance: write at the edge ending the accept cycle, data two cycles later.
  logic [DW-1:0] mem_arr [0:16383];
  logic [DW-1:0] rd1;

  always @(posedge clk) if (mem_we != '0) mem_arr[mem_addr] <= mem_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1       <= '0;
      mem_rdata <= '0;
    end else begin
      rd1       <= mem_arr[mem_addr];
      mem_rdata <= rd1;
    end
  end

  function automatic logic [31:0] init_val(int i);
    if (i < 4)   return 32'hA0A0_0000 | 32'(i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h0001_0001) ^ 32'h5A5A_5A5A;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] shadow [0:16383];
  int          m_last = 1;
  int          m_burst = 0;
  int          cyc = 0;
  int          m_g, m_a;
  bit          m_wr, e_rv0, e_rv1, e_busy;
  logic [31:0] m_wd, e_data;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      pend.delete();
      m_last  = 1;
      m_burst = 0;
    end else begin
      m_g = -1;
      if (m0_valid && !m1_valid)      m_g = 0;
      else if (m1_valid && !m0_valid) m_g = 1;
      else if (m0_valid && m1_valid) begin
        if (m_burst >= LM)                                m_g = 0;
        else if (m1_lock && m_last == 1 && m_burst > 0)   m_g = 1;
        else                                              m_g = 1 - m_last;
      end
      m_wr = 0; m_a = 0; m_wd = 0;
      if (m_g == 0) begin m_wr = m0_we; m_a = int'(m0_addr); m_wd = m0_wdata; end
      if (m_g == 1) begin m_wr = m1_we; m_a = int'(m1_addr); m_wd = m1_wdata; end

      chk("m0_ready", m0_ready, (m_g == 0) ? 1 : 0);
      chk("m1_ready", m1_ready, (m_g == 1) ? 1 : 0);
      chk("mem_addr", mem_addr, 32'(m_a));
      chk("mem_wdata", mem_wdata, m_wd);
      chk("mem_we", mem_we, (m_g >= 0 && m_wr) ? 32'hFFFF_FFFF : 32'h0);

      e_rv0 = 0; e_rv1 = 0; e_busy = 0; e_data = 0;
      foreach (pend[k]) begin
        if (pend[k].due == cyc) begin
          if (pend[k].id == 0) e_rv0 = 1; else e_rv1 = 1;
          e_data = pend[k].data;
        end
        if (pend[k].due == cyc || pend[k].due == cyc + 1) e_busy = 1;
      end
      chk("m0_rvalid", m0_rvalid, e_rv0);
      chk("m1_rvalid", m1_rvalid, e_rv1);
      chk("busy", busy, e_busy);
      chk("m0_rdata_mirror", m0_rdata, mem_rdata);
      chk("m1_rdata_mirror", m1_rdata, mem_rdata);
      if (e_rv0 || e_rv1) chk("rsp_data", e_rv0 ? m0_rdata : m1_rdata, e_data);

      if (m_g >= 0) begin
        if (m_wr) shadow[m_a] = m_wd;
        else      pend.push_back('{due: cyc + 2, id: m_g, data: shadow[m_a]});
        m_last = m_g;
      end
      if (m_g == 0 || !m1_lock)         m_burst = 0;
      else if (m_g == 1 && m0_valid)    m_burst = (m_burst + 1 > LM) ? LM : m_burst + 1;
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    end
    cyc++;
  end

  // Directed stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(bit v, bit we, int addr, logic [31:0] wd);
    m0_valid = v; m0_we = we; m0_addr = AW'(addr); m0_wdata = wd;
  endtask

  task automatic drv1(bit v, bit we, int addr, logic [31:0] wd);
    m1_valid = v; m1_we = we; m1_addr = AW'(addr); m1_wdata = wd;
  endtask

  function automatic int gnt_now();
    if (m0_ready && m1_ready) return 2;
    if (m0_ready) return 0;
    if (m1_ready) return 1;
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem_arr[i] = init_val(i);
      shadow[i]  = init_val(i);
    end
    drv0(1, 0, 16, 0);
    drv1(1, 0, 1, 0);
    m1_lock = 1'b0;
    #4;
    chk("lit_rst_ready0", m0_ready, 0);
    chk("lit_rst_ready1", m1_ready, 0);
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single m0 read of 0x0010
    step();
    drv0(1, 0, 16, 0);
    #3;
    chk("lit_t1_ready", m0_ready, 1);
    chk("lit_t1_addr", mem_addr, 16);
    step();
    drv0(0, 0, 0, 0);
    #3;
    chk("lit_t1_rv_early", m0_rvalid, 0);
    step();
    #3;
    chk("lit_t1_rv", m0_rvalid, 1);
    chk("lit_t1_data", m0_rdata, 32'hDEADBEEF);
    chk("lit_t1_rv1", m1_rvalid, 0);
    step();
    #3;
    chk("lit_t1_rv_late", m0_rvalid, 0);

    // Write 0x0020 then read it back next cycle
    step();
    drv0(1, 1, 32, 32'h12345678);
    #3;
    chk("lit_t2_we", mem_we, 32'hFFFF_FFFF);
    step();
    drv0(1, 0, 32, 0);
    #3;
    chk("lit_t2_we_rd", mem_we, 0);
    step();
    drv0(0, 0, 0, 0);
    #3;
    chk("lit_t2_rv_early", m0_rvalid, 0);
    step();
    #3;
    chk("lit_t2_rv", m0_rvalid, 1);
    chk("lit_t2_data", m0_rdata, 32'h12345678);

    // Read in flight, async reset pulse mid-cycle drops it
    step();
    drv0(1, 0, 16, 0);
    step();
    drv0(0, 0, 0, 0);
    #1 rst = 1'b1;
    #4;
    chk("lit_t6_busy_rst", busy, 0);
    chk("lit_t6_rv_rst", m0_rvalid, 0);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      #3;
      chk("lit_t6_no_rv", m0_rvalid, 0);
    end

    // Both valid, no lock: alternate starting with m0
    step();
    drv0(1, 0, 256, 0);
    drv1(1, 0, 512, 0);
    for (int k = 0; k < 8; k++) begin
      #3;
      chk("lit_t3_alt", gnt_now(), k % 2);
      step();
    end
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);

    // Fresh reset, then lock burst against a waiting m0
    #1 rst = 1'b1;
    #4 rst = 1'b0;
    step();
    drv0(1, 0, 64, 0);
    drv1(1, 0, 128, 0);
    m1_lock = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #3;
      chk("lit_t4_lock", gnt_now(), (k == 0 || k == 17) ? 0 : 1);
      step();
    end
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    m1_lock = 1'b0;
    repeat (3) step();

    // Back-to-back m1 reads of 0x0000..0x0003
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drv1(1, 0, k, 0);
      else       drv1(0, 0, 0, 0);
      #3;
      if (k < 4)  chk("lit_t5_ready", m1_ready, 1);
      if (k >= 1) chk("lit_t5_busy", busy, 1);
      if (k >= 2) begin
        chk("lit_t5_rv", m1_rvalid, 1);
        chk("lit_t5_data", m1_rdata, 32'hA0A0_0000 + 32'(k - 2));
      end
      chk("lit_t5_rv0", m0_rvalid, 0);
      step();
    end

    // Mixed traffic on a small address window, checked by the model
    for (int k = 0; k < 300; k++) begin
      drv0($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom);
      drv1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom);
      m1_lock = ($urandom_range(0, 9) != 0);
      step();
    end
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    m1_lock = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the data port (port b) of the dual-port 16K x 32 instruction/data memory between two requesters.
  - m0: CPU load/store unit.
  - m1: UART boot-loader / DMA.
- Per-cycle 2-way round-robin arbitration, with a bounded burst lock for m1.
- Tracks the memory's fixed 2-cycle read latency with a tag pipeline and steers each read response to the requester that issued it.
- Sits between the MEM stage / loader and the memory instance.

Parameters:
- ADDR_W, 14, word-address width (16384 words).
- DATA_W, 32, data width.
- LOCK_MAX, 16, maximum consecutive m1 grants under m1_lock while m0 is waiting.

Ports:
- clk  in  1  system clock; the memory's port-b clock is the same clock.
- rst  in  1  asynchronous, active-high reset.
- m0_valid  in  1  CPU request valid.
- m0_ready  out  1  CPU request accepted this cycle.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  word address.
- m0_wdata  in  DATA_W  write data.
- m0_rvalid  out  1  read data for m0 valid this cycle.
- m0_rdata  out  DATA_W  read data.
- m1_valid, m1_ready, m1_we, m1_addr, m1_wdata, m1_rvalid, m1_rdata: same as m0, for the loader.
- m1_lock  in  1  loader requests a back-to-back burst.
- mem_addr  out  ADDR_W  to memory port-b address.
- mem_wdata  out  DATA_W  to memory port-b write data.
- mem_we  out  DATA_W  port-b write enable; all-ones on an accepted write, else zero.
- mem_rdata  in  DATA_W  from memory port-b read data.
- busy  out  1  any read in flight in the tag pipeline.

Behaviour:
- Accept rule: request i is accepted in cycle t when mi_valid && mi_ready. Ready is combinational from valid, arbiter state and lock; at most one ready is high per cycle.
- Memory drive:
  - mem_addr, mem_wdata and mem_we are combinational from the accepted requester.
  - With no accept: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Read latency: a read accepted in cycle t has data valid in cycle t+2.
  - mi_rvalid is high for exactly that one cycle.
  - mi_rdata = mem_rdata in that cycle. Both rdata outputs mirror mem_rdata at all times; only rvalid is gated.
  - Requesters cannot stall responses.
- Write: accepted in cycle t, committed at the end of t. No rvalid is generated for writes. A read of the same address accepted in t+1 returns the new data.
- Throughput: one accept per cycle; reads and writes are fully pipelined with no bubbles.
- Tag pipeline: two stages of {vld, id, rd}.
  - Stage 1 loads at the end of the accept cycle; stage 2 loads from stage 1 on the next edge.
  - rvalid_i = s2.vld && s2.rd && s2.id == i.
  - busy = s1.vld&&s1.rd || s2.vld&&s2.rd.
- Arbitration state: last (1 bit; 0 = m0, 1 = m1) and lock_cnt (log2(LOCK_MAX)+1 bits).
  - One valid only: that requester is granted.
  - Both valid, no lock: grant !last.
  - Both valid, m1_lock=1, last=1, lock_cnt < LOCK_MAX: grant m1.
  - Both valid, lock_cnt == LOCK_MAX: grant m0. This forced m0 grant clears lock_cnt.
- lock_cnt rules:
  - Increments on each m1 grant made while m0_valid and m1_lock are high.
  - Clears on any m0 grant, or when m1_lock = 0.
  - Saturates at LOCK_MAX.
- last updates to the granted id on every accept. It holds when nothing is accepted.
- Simultaneous events: a response delivered and a new accept in the same cycle are independent; both proceed.
- Reset: asynchronous.
  - All outputs 0; last = 1, so m0 wins the first contention.
  - lock_cnt = 0; tag pipeline cleared.
  - Reads in flight at reset assertion are dropped and never produce rvalid.

Decomposition:
- Package mem_arb_pkg:
  - ADDR_W and DATA_W constants.
  - typedef mem_req_t {we, addr, wdata}.
  - typedef rsp_tag_t {vld, id, rd}.
  - Requester id constants REQ_CPU = 0, REQ_LDR = 1.
- One sub-module: mem_rsp_tag_pipe.
  - Contains the 2-stage rsp_tag_t shift register with async reset.
  - Produces the per-requester rvalid and busy outputs.
- Arbitration and lock logic stay in the top module.

Test Plan:
- m0 read @0x0010, memory word = 0xDEADBEEF -> m0_ready in t, m0_rvalid only in t+2 with m0_rdata = 0xDEADBEEF, m1_rvalid stays 0.
- m0 writes 0x12345678 @0x0020 in t, then reads 0x0020 in t+1 -> rvalid in t+3 with 0x12345678; mem_we = 0xFFFFFFFF only in t.
- Both valid continuously, no lock, after reset -> grants alternate m0, m1, m0, m1; each read's rvalid goes to the correct requester 2 cycles after its accept.
- m1_lock=1 and m0_valid held from cycle 0 -> first grant m0, then LOCK_MAX=16 consecutive m1 grants, then one m0 grant, then the m1 burst resumes.
- Back-to-back m1 reads to 0x0000..0x0003 -> 4 accepts in 4 cycles; rvalid in 4 consecutive cycles, data in order; busy high throughout.
- Read accepted, rst pulsed asynchronously mid-cycle before data returns -> no rvalid afterwards; all outputs 0 during reset; the first post-reset contention is granted to m0.
